mdu_sequencer: RTL and testbench

Iterative RISC-V M-extension unit plus its controller, placed beside the execute-stage ALU.
- Accepts one multiply/divide op at a time and runs a 32-step shift-add / shift-subtract datapath.
- Holds the pipeline via stall until the result is ready.
- Returns one registered result to the EX/MEM path.

---
 rtl/mdu_sequencer.sv | 171 +++++++++++++++++
 tb/tb_mdu_sequencer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_sequencer.sv
// Iterative RISC-V M-extension multiply/divide unit with its sequencing FSM.
// Optional single-cycle multiplier enabled by defining MDU_FAST_MUL_EN.
module mdu_sequencer #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_fun,
    input  logic [XLEN-1:0] op1_data,
    input  logic [XLEN-1:0] op2_data,
    input  logic            flush,
    output logic            stall,
    output logic            result_valid,
    output logic [XLEN-1:0] result
);

    localparam int IDX_W = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t state, state_nx;

    logic [CNT_W-1:0]  cnt;
    logic [2:0]        fun_q;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic              neg_q, neg_r;
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   quo, rem;

    // Handshake: an op transfers on any cycle where req_valid && req_ready && !flush;
    // req_ready is high only in IDLE, and the op is held off for flush in that cycle.
    logic accept;
    assign accept = (state == IDLE) && req_valid && !flush;

    logic op1_signed, op2_signed, op1_neg, op2_neg;
    logic [XLEN-1:0] op1_mag, op2_mag;
    logic div_zero, div_ovf, special, fast_mul;

    always_comb begin
        op1_signed = (req_fun == 3'd1) || (req_fun == 3'd2) || (req_fun == 3'd4) || (req_fun == 3'd6);
        op2_signed = (req_fun == 3'd1) || (req_fun == 3'd4) || (req_fun == 3'd6);
        op1_neg    = op1_signed && op1_data[XLEN-1];
        op2_neg    = op2_signed && op2_data[XLEN-1];
        op1_mag    = op1_neg ? -op1_data : op1_data;
        op2_mag    = op2_neg ? -op2_data : op2_data;
        div_zero   = req_fun[2] && (op2_data == '0);
        div_ovf    = ((req_fun == 3'd4) || (req_fun == 3'd6)) &&
                     (op1_data == {1'b1, {(XLEN-1){1'b0}}}) && (op2_data == '1);
        special    = div_zero || div_ovf;
`ifdef MDU_FAST_MUL_EN
        fast_mul   = !req_fun[2];
`else
        fast_mul   = 1'b0;
`endif
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (accept) state_nx = (special || fast_mul) ? FIX : CALC;
            CALC: if (cnt == CNT_W'(XLEN-1)) state_nx = FIX;
            FIX:  state_nx = DONE;
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (flush && state != IDLE) state_nx = IDLE;
    end

    // Output logic
    always_comb begin
        req_ready    = (state == IDLE);
        result_valid = (state == DONE);
        stall        = (state == CALC) || (state == FIX) ||
                       ((state == IDLE) && req_valid && !flush);
    end

    // Per-iteration datapath terms
    logic [IDX_W-1:0]  bit_idx, div_idx;
    logic [2*XLEN-1:0] mul_addend;
    logic [XLEN:0]     rem_shift, rem_diff;
    logic              rem_ge;

    always_comb begin
        bit_idx    = cnt[IDX_W-1:0];
        div_idx    = IDX_W'(XLEN-1) - bit_idx;
        mul_addend = b_mag[bit_idx] ? ({{XLEN{1'b0}}, a_mag} << bit_idx) : '0;
        rem_shift  = {rem, a_mag[div_idx]};
        rem_ge     = rem_shift >= {1'b0, b_mag};
        rem_diff   = rem_shift - {1'b0, b_mag};
    end

    // Sign fix-up and output select
    logic [2*XLEN-1:0] acc_s;
    logic [XLEN-1:0]   quo_s, rem_s, fix_val;

    always_comb begin
        acc_s = neg_q ? -acc : acc;
        quo_s = neg_q ? -quo : quo;
        rem_s = neg_r ? -rem : rem;
        case (fun_q)
            3'd0:          fix_val = acc_s[XLEN-1:0];
            3'd1, 3'd2,
            3'd3:          fix_val = acc_s[2*XLEN-1:XLEN];
            3'd4, 3'd5:    fix_val = quo_s;
            default:       fix_val = rem_s;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            fun_q  <= '0;
            a_mag  <= '0;
            b_mag  <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            acc    <= '0;
            quo    <= '0;
            rem    <= '0;
            result <= '0;
        end else begin
            if (accept) begin
                cnt   <= '0;
                fun_q <= req_fun;
                a_mag <= op1_mag;
                b_mag <= op2_mag;
                neg_q <= op1_neg ^ op2_neg;
                neg_r <= op1_neg;
                acc   <= '0;
                quo   <= '0;
                rem   <= '0;
                // Special divides preload the final answer so FIX needs no extra path
                if (div_zero) begin
                    neg_q <= 1'b0;
                    neg_r <= 1'b0;
                    quo   <= '1;
                    rem   <= op1_data;
                end else if (div_ovf) begin
                    neg_q <= 1'b0;
                    neg_r <= 1'b0;
                    quo   <= {1'b1, {(XLEN-1){1'b0}}};
                    rem   <= '0;
                end
`ifdef MDU_FAST_MUL_EN
                if (fast_mul)
                    acc <= {{XLEN{1'b0}}, op1_mag} * {{XLEN{1'b0}}, op2_mag};
`endif
            end else if (state == CALC) begin
                cnt <= cnt + CNT_W'(1);
                if (fun_q[2]) begin
                    rem          <= rem_ge ? rem_diff[XLEN-1:0] : rem_shift[XLEN-1:0];
                    quo[div_idx] <= rem_ge;
                end else begin
                    acc <= acc + mul_addend;
                end
            end
            if (state == FIX && !flush) result <= fix_val;
        end
    end

endmodule

// File: tb/tb_mdu_sequencer.sv
// Randomised scoreboard bench for mdu_sequencer against an arithmetic reference model.
module tb_mdu_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_fun;
  logic [31:0] op1_data;
  logic [31:0] op2_data;
  logic        flush;
  logic        stall;
  logic        result_valid;
  logic [31:0] result;

  mdu_sequencer dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_fun(req_fun), .op1_data(op1_data), .op2_data(op2_data),
    .flush(flush), .stall(stall), .result_valid(result_valid), .result(result)
  );

  // Clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] exp_q[$];
  int          lat_q[$];
  int          acc_q[$];
  int          n_checks = 0;
  int          n_pass = 0;
  bit          in_flight = 1'b0;
  int          stall_err = 0;
  logic [31:0] last_result = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference model: RISC-V M semantics in plain 64-bit arithmetic
  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint          sa = $signed(a);
    longint          sb = $signed(b);
    longint unsigned ua = {32'b0, a};
    longint unsigned ub = {32'b0, b};
    logic [63:0]     p;
    logic            ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'($signed(a) / $signed(b));
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && b == 0) return 2;
    if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
`ifdef MDU_FAST_MUL_EN
    if (!f[2]) return 2;
`endif
    return 34;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Driver: present an op and hold it until accepted
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input bit track);
    int waited = 0;
    @(negedge clk);
    req_fun = f; op1_data = a; op2_data = b; req_valid = 1'b1;
    #1;
    while (!req_ready && waited < 100) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (!req_ready) begin
      check("accept_timeout", req_ready, 1);
      req_valid = 1'b0;
      return;
    end
    if (track) begin
      exp_q.push_back(ref_model(f, a, b));
      lat_q.push_back(exp_lat(f, a, b));
      acc_q.push_back(cyc + 1);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    if (track) in_flight = 1'b1;
  endtask

  task automatic wait_done();
    int n = 0;
    while (in_flight && n < 200) begin
      @(negedge clk);
      #2;
      n++;
    end
    if (in_flight) begin
      check("done_timeout", in_flight, 0);
      in_flight = 1'b0;
      exp_q.delete(); lat_q.delete(); acc_q.delete();
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (in_flight && !result_valid && !stall) stall_err++;
      if (result_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid", result_valid, 0);
        end else begin
          logic [31:0] e;
          int l, a;
          e = exp_q.pop_front();
          l = lat_q.pop_front();
          a = acc_q.pop_front();
          check("result", result, e);
          check("latency", cyc - a + 1, l);
          check("stall_hold", stall_err, 0);
          check("done_hs", {stall, req_ready}, 0);
          last_result = e;
          stall_err = 0;
          in_flight = 1'b0;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  logic [2:0]  d_fun[12] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd7, 3'd4, 3'd6};
  logic [31:0] d_a[12]   = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                             32'd100, 32'd100, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
  logic [31:0] d_b[12]   = '{32'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd2,
                             32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};

  initial begin
    rst = 1'b1; req_valid = 1'b0; flush = 1'b0; req_fun = '0; op1_data = '0; op2_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_ready", req_ready, 1);
    check("reset_stall", stall, 0);
    check("reset_valid", result_valid, 0);
    check("reset_result", result, 0);

    // Directed ops from the plan
    for (int i = 0; i < 12; i++) begin
      issue(d_fun[i], d_a[i], d_b[i], 1'b1);
      wait_done();
    end

    // Flush mid-CALC
    issue(3'd5, 32'd1000, 32'd3, 1'b0);
    repeat (9) @(negedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("flush_stall", stall, 0);
    check("flush_ready", req_ready, 1);
    repeat (40) @(negedge clk);
    check("flush_result_kept", result, last_result);
    issue(3'd0, 32'd3, 32'd3, 1'b1);
    wait_done();

    // Flush with request in IDLE: no accept
    @(negedge clk);
    req_fun = 3'd0; op1_data = 32'd2; op2_data = 32'd2; req_valid = 1'b1; flush = 1'b1;
    #1 check("flush_idle_stall", stall, 0);
    @(posedge clk);
    #1 req_valid = 1'b0; flush = 1'b0;
    check("flush_idle_no_accept", req_ready, 1);
    repeat (40) @(negedge clk);

    // Flush in DONE: pulse still delivered
    issue(3'd4, 32'd5, 32'd0, 1'b1);
    @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    check("flush_done_consumed", in_flight, 0);
    check("flush_done_ready", req_ready, 1);

    // Async reset mid-CALC
    issue(3'd5, 32'd77, 32'd5, 1'b0);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_ready", req_ready, 1);
    check("arst_stall", stall, 0);
    check("arst_valid", result_valid, 0);
    check("arst_result", result, 0);
    @(negedge clk);
    rst = 1'b0;
    last_result = '0;
    issue(3'd7, 32'd9, 32'd4, 1'b1);
    wait_done();

    // Random back-to-back ops
    for (int i = 0; i < 40; i++) begin
      issue(3'($urandom_range(0, 7)), pick_operand(), pick_operand(), 1'b1);
    end
    wait_done();
    repeat (5) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
